// File: rtl/ext_pulse_generator_pkg.sv
// Shared types and constants for the external pulse generator.
// Holds the control state encoding, the derived field widths and the
// reset defaults used when the top-level parameters are left untouched.
package ext_pulse_generator_pkg;

    localparam int unsigned TIMER_WIDTH    = 32;
    localparam logic [31:0] DEFAULT_PERIOD = 32'd100000000;
    localparam logic [31:0] DEFAULT_COUNT  = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Window length L = P + 1 needs one extra bit so P = all-ones cannot wrap.
    function automatic int unsigned len_width(input int unsigned timer_width);
        return timer_width + 32'd1;
    endfunction

    // acc + N may reach just under 2L, so the sum needs two extra bits.
    function automatic int unsigned sum_width(input int unsigned timer_width);
        return timer_width + 32'd2;
    endfunction

endpackage

// File: rtl/ext_pulse_dda.sv
// Digital differential analyser that spreads N events over L cycles.
// Each stepped cycle adds N to the accumulator; when the sum reaches L
// an event fires and L is subtracted, so exactly N events occur per L steps.
module ext_pulse_dda
    import ext_pulse_generator_pkg::*;
#(
    parameter int unsigned TimerWidth = TIMER_WIDTH
) (
    input  logic                               i_clock,
    input  logic                               i_reset_n,
    input  logic [len_width(TimerWidth)-1:0]   i_n,
    input  logic [len_width(TimerWidth)-1:0]   i_len,
    input  logic                               i_clear,
    input  logic                               i_step,
    output logic                               o_fire
);

    localparam int unsigned LW = len_width(TimerWidth);
    localparam int unsigned SW = sum_width(TimerWidth);

    logic [LW-1:0] r_acc;
    logic [SW-1:0] w_sum;
    logic [SW-1:0] w_len_ext;
    logic          w_reach;
    logic [LW-1:0] w_rem;

    assign w_sum     = {1'b0, r_acc} + {1'b0, 1'b0, i_n};
    assign w_len_ext = {1'b0, i_len};
    assign w_reach   = (w_sum >= w_len_ext);
    assign w_rem     = w_reach ? LW'(w_sum - w_len_ext) : LW'(w_sum);
    assign o_fire    = i_step & w_reach;

    // Accumulator: clear has priority so every window starts from zero.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_acc <= {LW{1'b0}};
        end else if (i_clear) begin
            r_acc <= {LW{1'b0}};
        end else if (i_step) begin
            r_acc <= w_rem;
        end else begin
            r_acc <= r_acc;
        end
    end

endmodule

// File: rtl/ext_pulse_generator.sv
// External pulse generator: emits min(N, P+1) evenly spaced single-cycle
// pulses in every window of P+1 cycles. Settings are captured into pending
// registers and copied to the active set only at window start, so a
// running window is never disturbed. All outputs are registered.
module ext_pulse_generator
    import ext_pulse_generator_pkg::*;
#(
    parameter int unsigned           TimerWidth    = TIMER_WIDTH,
    parameter logic [TimerWidth-1:0] DefaultPeriod = TimerWidth'(DEFAULT_PERIOD),
    parameter logic [TimerWidth-1:0] DefaultCount  = TimerWidth'(DEFAULT_COUNT)
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iEnabled,
    input  logic [TimerWidth-1:0] iPeriodSetting,
    input  logic [TimerWidth-1:0] iCountSetting,
    input  logic                  iSettingValid,
    output logic                  oPulse,
    output logic                  oWindowDone,
    output logic [TimerWidth-1:0] oEmittedCount,
    output logic [TimerWidth-1:0] oPeriodValue,
    output logic [TimerWidth-1:0] oCountValue
);

    localparam int unsigned LW = len_width(TimerWidth);

    state_t                r_state;
    logic [TimerWidth-1:0] r_period_pend;
    logic [TimerWidth-1:0] r_count_pend;
    logic [LW-1:0]         r_len_act;
    logic [LW-1:0]         r_n_act;
    logic [TimerWidth-1:0] r_timer;
    logic [LW-1:0]         r_tally;
    logic                  r_pulse;
    logic                  r_window_done;
    logic [TimerWidth-1:0] r_emitted;

    logic [LW-1:0]         w_len_pend;
    logic [LW-1:0]         w_count_pend_ext;
    logic [LW-1:0]         w_n_pend_clamped;
    logic                  w_reload;
    logic                  w_dda_clear;
    logic                  w_dda_step;
    logic                  w_fire;
    logic [LW-1:0]         w_tally_next;

    assign w_len_pend       = {1'b0, r_period_pend} + {{TimerWidth{1'b0}}, 1'b1};
    assign w_count_pend_ext = {1'b0, r_count_pend};
    assign w_n_pend_clamped = (w_count_pend_ext > w_len_pend) ? w_len_pend : w_count_pend_ext;
    assign w_reload         = (r_state == ST_RUN) && (r_timer == {TimerWidth{1'b0}});
    assign w_dda_step       = (r_state == ST_RUN) && iEnabled;
    assign w_dda_clear      = (r_state != ST_RUN) || w_reload;
    assign w_tally_next     = r_tally + {{TimerWidth{1'b0}}, w_fire};

    ext_pulse_dda #(
        .TimerWidth (TimerWidth)
    ) u_dda (
        .i_clock   (iClock),
        .i_reset_n (iReset),
        .i_n       (r_n_act),
        .i_len     (r_len_act),
        .i_clear   (w_dda_clear),
        .i_step    (w_dda_step),
        .o_fire    (w_fire)
    );

    // Control FSM with settings capture, window timer, tally and registered outputs.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            r_state       <= ST_IDLE;
            r_period_pend <= DefaultPeriod;
            r_count_pend  <= DefaultCount;
            r_len_act     <= {LW{1'b0}};
            r_n_act       <= {LW{1'b0}};
            r_timer       <= {TimerWidth{1'b0}};
            r_tally       <= {LW{1'b0}};
            r_pulse       <= 1'b0;
            r_window_done <= 1'b0;
            r_emitted     <= {TimerWidth{1'b0}};
        end else begin
            r_pulse       <= 1'b0;
            r_window_done <= 1'b0;
            if (iSettingValid) begin
                r_period_pend <= iPeriodSetting;
                r_count_pend  <= iCountSetting;
            end else begin
                r_period_pend <= r_period_pend;
                r_count_pend  <= r_count_pend;
            end
            case (r_state)
                ST_IDLE: begin
                    if (iEnabled) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (!iEnabled) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_len_act <= w_len_pend;
                        r_n_act   <= w_n_pend_clamped;
                        r_timer   <= r_period_pend;
                        r_tally   <= {LW{1'b0}};
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!iEnabled) begin
                        // Partial window is dropped: no done strobe, count holds.
                        r_state <= ST_IDLE;
                    end else begin
                        r_pulse <= w_fire;
                        if (w_reload) begin
                            // Window end and next-window load share one edge.
                            r_window_done <= 1'b1;
                            r_emitted     <= w_tally_next[TimerWidth-1:0];
                            r_len_act     <= w_len_pend;
                            r_n_act       <= w_n_pend_clamped;
                            r_timer       <= r_period_pend;
                            r_tally       <= {LW{1'b0}};
                        end else begin
                            r_timer <= r_timer - {{(TimerWidth-1){1'b0}}, 1'b1};
                            r_tally <= w_tally_next;
                        end
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oPulse        = r_pulse;
    assign oWindowDone   = r_window_done;
    assign oEmittedCount = r_emitted;
    assign oPeriodValue  = r_period_pend;
    assign oCountValue   = r_count_pend;

endmodule

// File: doc/ext_pulse_generator.md
Name: ext_pulse_generator

Overview:
- Stimulus-side counterpart of the external rate counter.
- Emits a programmed number N of single-cycle pulses, evenly spread over each measurement window of P+1 clock cycles.
- Window framing matches the counter: the timer reloads P and counts down to 0.
- Used on-chip to drive probe inputs for rate loopback and to pace traffic injectors at a fixed event rate.

Parameters:
- TimerWidth, 32, width of period, count and accumulator fields.
- DefaultPeriod, 100000000, period P loaded at reset; window length is P+1 cycles.
- DefaultCount, 0, pulses per window N loaded at reset.

Ports:
- iClock  in  1  single clock; all logic on rising edge.
- iReset  in  1  asynchronous, active-low reset.
- iEnabled  in  1  run enable; low forces IDLE.
- iPeriodSetting  in  TimerWidth  new P.
- iCountSetting  in  TimerWidth  new N.
- iSettingValid  in  1  one-cycle strobe capturing both settings.
- oPulse  out  1  generated event, one cycle per event.
- oWindowDone  out  1  one-cycle strobe marking the final cycle of a window.
- oEmittedCount  out  TimerWidth  pulses emitted in the last completed window.
- oPeriodValue  out  TimerWidth  pending (programmed) P.
- oCountValue  out  TimerWidth  pending (programmed) N.

Behaviour:
- Reset (iReset=0, async): pending P=DefaultPeriod, N=DefaultCount; state IDLE; oPulse=0, oWindowDone=0, oEmittedCount=0; accumulator, timer and window tally cleared.
- iSettingValid: pending P/N update on the next edge and are visible on oPeriodValue/oCountValue in the following cycle. Active copies change only in LOAD, so a window in progress is never altered.
- States:
  - IDLE: oPulse=0; leave to LOAD when iEnabled=1.
  - LOAD (1 cycle): active P <- pending P; L = P+1, held in TimerWidth+1 bits. Active N <- min(pending N, L). Timer <- P; accumulator <- 0; tally <- 0. Go to RUN.
  - RUN: each cycle, sum = acc + N (TimerWidth+2 bits).
    - If sum >= L: fire; acc <- sum - L; tally +1.
    - Else: acc <- sum.
    - If timer == 0: window ends; return to LOAD-equivalent reload in the same edge, with no bubble cycle. Otherwise timer decrements.
- Back-to-back windows: the reload at timer==0 performs the LOAD actions in place. LOAD as a separate cycle occurs only on exit from IDLE.
- Outputs are registered, so every output appears one cycle after its decision cycle:
  - oPulse = the fire decision from the previous cycle.
  - oWindowDone and oEmittedCount (final tally including the last cycle) update in the same cycle as the oPulse for the window's last decision.
- Exactness: the accumulator returns to 0 at every window end. Each window therefore carries exactly min(N, L) pulses. Pulse spacing is floor or ceil of L/N.
- Boundaries:
  - N=0: no pulses; oEmittedCount=0 each window.
  - N>=L: pulse every cycle; count = L.
  - P=0: L=1, window of 1 cycle.
  - P = 2^TimerWidth-1: L needs the extra bit and must not overflow.
- iEnabled low mid-window: next state IDLE; oPulse=0 from the following cycle. The partial window is discarded; oEmittedCount and oWindowDone do not update. Re-enable starts a fresh window via LOAD.
- Async reset mid-window: all state cleared immediately; no partial results.
- iSettingValid in the same cycle as a reload: the reload uses the old pending values; new values apply at the next window.

Decomposition:
- Shared package:
  - state enum (IDLE, LOAD, RUN).
  - TimerWidth-derived widths (L width = TimerWidth+1, sum width = TimerWidth+2).
  - reset defaults.
- Natural sub-module: ext_pulse_dda. It holds the accumulator, the compare/subtract and the fire output, with inputs N, L, clear and step.

Test Plan:
- P=9, N=5, enabled after reset → oPulse on alternate cycles; 5 pulses per 10-cycle window; oWindowDone every 10 cycles; oEmittedCount=5.
- P=9, N=3 → fire decisions at window cycle indices 3, 6, 9; oPulse one cycle later; oEmittedCount=3; pattern repeats identically across windows.
- P=9, N=15 → N clamped to 10; oPulse constantly high while RUN; oEmittedCount=10. Separately, N=0 → oPulse never high; oEmittedCount=0.
- P=9, N=2 running; strobe P=4, N=5 at window cycle 4 → the current window completes with 2 pulses; oPeriodValue=4 next cycle; the following windows are 5 cycles long with pulses every cycle, oEmittedCount=5.
- Deassert iEnabled at window cycle 6 → oPulse low from the next cycle; no oWindowDone; oEmittedCount holds its previous value. Re-enable → LOAD cycle, then a full fresh window.
- Assert iReset low asynchronously mid-window → outputs zero immediately; oPeriodValue=DefaultPeriod, oCountValue=DefaultCount. Release → IDLE; LOAD once iEnabled=1.
